// File: rtl/frame_align_param_pkg.sv
// Shared types and defaults for the frame aligner.
package frame_align_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } fa_state_e;

    localparam int          DEF_DATA_W        = 8;
    localparam int          DEF_HDR_BYTES     = 2;
    localparam int          DEF_PAYLOAD_BYTES = 10;
    localparam int          DEF_LOCK_CNT      = 3;
    localparam int          DEF_UNLOCK_MISS   = 4;
    localparam logic [15:0] DEF_HDR_A         = 16'hAFAA;
    localparam logic [15:0] DEF_HDR_B         = 16'hBA55;

    // Header type from the two match flags; A wins when both patterns match.
    function automatic logic sel_hdr_type(input logic match_a, input logic match_b);
        return !match_a && match_b;
    endfunction

endpackage

// File: rtl/frame_align_param_if.sv
// Receive-side stream and aligner status bundle.
interface frame_align_param_if #(
    parameter int DATA_W = 8,
    parameter int POS_W  = 4
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              frame_detect;
    logic [POS_W-1:0]  fr_byte_position;
    logic              hdr_type;

    modport master (output rx_valid, rx_data,
                    input  frame_detect, fr_byte_position, hdr_type);
    modport slave  (input  rx_valid, rx_data,
                    output frame_detect, fr_byte_position, hdr_type);
endinterface

// File: rtl/frame_align_param_matcher.sv
// Header matcher: the window is the previous HDR_BYTES-1 accepted symbols plus
// the symbol currently on the bus, so a match is seen on the accepting cycle.
module frame_hdr_matcher #(
    parameter int                           DATA_W    = 8,
    parameter int                           HDR_BYTES = 2,
    parameter logic [HDR_BYTES*DATA_W-1:0]  HDR_A     = 16'hAFAA,
    parameter logic [HDR_BYTES*DATA_W-1:0]  HDR_B     = 16'hBA55
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              match_a_o,
    output logic              match_b_o
);
    logic [HDR_BYTES*DATA_W-1:0] window;

    if (HDR_BYTES == 1) begin : g_one
        assign window = data_i;
    end else begin : g_sh
        logic [(HDR_BYTES-1)*DATA_W-1:0] shreg_q;

        assign window = {shreg_q, data_i};

        // History of accepted symbols; wiped when the aligner falls back to search.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)          shreg_q <= '0;
            else if (clr_i)      shreg_q <= '0;
            else if (shift_en_i) shreg_q <= window[(HDR_BYTES-1)*DATA_W-1:0];
        end
    end

    assign match_a_o = (window == HDR_A);
    assign match_b_o = (window == HDR_B);
endmodule

// File: rtl/frame_align_param.sv
// Frame aligner: search / verify / locked FSM with flywheel position counter.
// Optional statistics counters are built when FRAME_ALIGN_STATS_EN is defined.
module frame_align_param
    import frame_align_pkg::*;
#(
    parameter int                           DATA_W        = DEF_DATA_W,
    parameter int                           HDR_BYTES     = DEF_HDR_BYTES,
    parameter int                           PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
    parameter int                           LOCK_CNT      = DEF_LOCK_CNT,
    parameter int                           UNLOCK_MISS   = DEF_UNLOCK_MISS,
    parameter logic [HDR_BYTES*DATA_W-1:0]  HDR_A         = DEF_HDR_A,
    parameter logic [HDR_BYTES*DATA_W-1:0]  HDR_B         = DEF_HDR_B
) (
    input  logic               clk,
    input  logic               reset,
    frame_align_param_if.slave bus
`ifdef FRAME_ALIGN_STATS_EN
   ,input  logic               stats_clr,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         sync_loss_cnt
`endif
);
    localparam int FRAME_LEN = HDR_BYTES + PAYLOAD_BYTES;
    localparam int POS_W     = $clog2(FRAME_LEN);
    localparam int GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam int MISS_W    = $clog2(UNLOCK_MISS + 1);
    localparam logic [POS_W-1:0] HDR_LAST = POS_W'(HDR_BYTES - 1);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(FRAME_LEN - 1);

    fa_state_e          state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d, pos_inc;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               ht_q, ht_d;
    logic               accept, match_a, match_b, hit, chk_slot, clr;

    assign accept   = bus.rx_valid;
    assign hit      = match_a | match_b;
    assign pos_inc  = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
    assign chk_slot = (pos_inc == HDR_LAST);
    assign clr      = accept && (state_d == SEARCH) && (state_q != SEARCH);

    frame_hdr_matcher #(
        .DATA_W(DATA_W), .HDR_BYTES(HDR_BYTES), .HDR_A(HDR_A), .HDR_B(HDR_B)
    ) u_match (
        .clk(clk), .reset(reset), .shift_en_i(accept), .clr_i(clr),
        .data_i(bus.rx_data), .match_a_o(match_a), .match_b_o(match_b)
    );

    // State and counter registers; everything holds while rx_valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEARCH;
            pos_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            ht_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            ht_q    <= ht_d;
        end
    end

    // Next state: headers are only examined at the header slot once aligned.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        good_d  = good_q;
        miss_d  = miss_q;
        ht_d    = ht_q;
        if (accept) begin
            case (state_q)
                SEARCH: begin
                    if (hit) begin
                        good_d  = GOOD_W'(1);
                        miss_d  = '0;
                        pos_d   = HDR_LAST;
                        ht_d    = sel_hdr_type(match_a, match_b);
                        state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end else begin
                        pos_d = '0;
                    end
                end
                VERIFY: begin
                    pos_d = pos_inc;
                    if (chk_slot) begin
                        if (hit) begin
                            ht_d = sel_hdr_type(match_a, match_b);
                            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                good_d  = GOOD_W'(LOCK_CNT);
                                miss_d  = '0;
                                state_d = LOCKED;
                            end else begin
                                good_d = good_q + GOOD_W'(1);
                            end
                        end else begin
                            state_d = SEARCH;
                            pos_d   = '0;
                            good_d  = '0;
                        end
                    end
                end
                LOCKED: begin
                    pos_d = pos_inc;
                    if (chk_slot) begin
                        if (hit) begin
                            miss_d = '0;
                            ht_d   = sel_hdr_type(match_a, match_b);
                        end else if (miss_q == MISS_W'(UNLOCK_MISS - 1)) begin
                            state_d = SEARCH;
                            pos_d   = '0;
                            good_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    pos_d   = '0;
                    good_d  = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    // Outputs straight from registers.
    always_comb begin
        bus.frame_detect     = (state_q == LOCKED);
        bus.fr_byte_position = pos_q;
        bus.hdr_type         = ht_q;
    end

`ifdef FRAME_ALIGN_STATS_EN
    logic        good_locked, lost_lock;
    logic [15:0] fcnt_q;
    logic [7:0]  slcnt_q;

    assign good_locked   = accept && (state_q == LOCKED) && chk_slot && hit;
    assign lost_lock     = accept && (state_q == LOCKED) && (state_d == SEARCH);
    assign frame_cnt     = fcnt_q;
    assign sync_loss_cnt = slcnt_q;

    // Saturating statistics; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_q  <= '0;
            slcnt_q <= '0;
        end else if (stats_clr) begin
            fcnt_q  <= '0;
            slcnt_q <= '0;
        end else begin
            if (good_locked && fcnt_q != 16'hFFFF) fcnt_q  <= fcnt_q + 16'd1;
            if (lost_lock && slcnt_q != 8'hFF)     slcnt_q <= slcnt_q + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_frame_align_param.sv
// Scoreboard bench for frame_align_param: stimulus pushes expected outputs,
// a monitor pops and compares one cycle after each accepted symbol and checks
// that outputs hold on stall cycles.
module tb_frame_align_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    frame_align_param_if #(.DATA_W(8), .POS_W(4)) bus ();

`ifdef FRAME_ALIGN_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] frame_cnt;
    logic [7:0]  sync_loss_cnt;
`endif

    frame_align_param dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
`ifdef FRAME_ALIGN_STATS_EN
       ,.stats_clr(stats_clr),
        .frame_cnt(frame_cnt),
        .sync_loss_cnt(sync_loss_cnt)
`endif
    );

    typedef struct packed {
        logic       fd;
        logic [3:0] pos;
        logic       ht;
    } exp_t;

    exp_t q[$];
    exp_t last_exp = '0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t act_now();
        return {bus.frame_detect, bus.fr_byte_position, bus.hdr_type};
    endfunction

    // Monitor: compare after every accepting edge, otherwise expect a hold.
    always @(posedge clk) begin : mon
        logic acc;
        exp_t e;
        acc = bus.rx_valid && reset;
        #1;
        if (reset) begin
            if (acc) begin
                if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("out{fd,pos,ht}", 32'(act_now()), 32'(e));
                    last_exp = e;
                end
            end else begin
                check("hold{fd,pos,ht}", 32'(act_now()), 32'(last_exp));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic fd, input logic [3:0] pos, input logic ht);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        q.push_back({fd, pos, ht});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'hAF;
        end
    endtask

    // One frame: two header symbols then payload 0x32..0x3B.
    // p1 = expected position after the second header symbol,
    // pl_srch = payload arrives in SEARCH (position stays 0),
    // stall_at = payload index before which rx_valid drops for 5 cycles.
    task automatic frame(input logic [7:0] h0, input logic [7:0] h1,
                         input logic fd0, input logic fd1, input logic fdp,
                         input logic ht0, input logic ht1,
                         input logic [3:0] p1, input logic pl_srch, input int stall_at);
        send(h0, fd0, 4'd0, ht0);
        send(h1, fd1, p1, ht1);
        for (int i = 2; i < 12; i++) begin
            if (i == stall_at) idle(5);
            send(8'(8'h30 + i), fdp, pl_srch ? 4'd0 : 4'(i), ht1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
        check("rst_frame_detect", 32'(bus.frame_detect), 32'd0);
        check("rst_position", 32'(bus.fr_byte_position), 32'd0);
        check("rst_hdr_type", 32'(bus.hdr_type), 32'd0);
        repeat (2) @(negedge clk);
        last_exp = '0;
        reset = 1'b1;
        idle(2);

        // Acquire lock with three AF AA frames.
        frame(8'hAF, 8'hAA, 0, 0, 0, 0, 0, 4'd1, 0, -1);
        frame(8'hAF, 8'hAA, 0, 0, 0, 0, 0, 4'd1, 0, -1);
        frame(8'hAF, 8'hAA, 0, 1, 1, 0, 0, 4'd1, 0, -1);

        // Alternate header types while locked.
        frame(8'hBA, 8'h55, 1, 1, 1, 0, 1, 4'd1, 0, -1);
        frame(8'hAF, 8'hAA, 1, 1, 1, 1, 0, 4'd1, 0, -1);
        frame(8'hBA, 8'h55, 1, 1, 1, 0, 1, 4'd1, 0, -1);
        frame(8'hAF, 8'hAA, 1, 1, 1, 1, 0, 4'd1, 0, -1);

        // Stall mid-payload.
        frame(8'hAF, 8'hAA, 1, 1, 1, 0, 0, 4'd1, 0, 6);

        // Four corrupted headers: flywheel through three, drop on the fourth.
        frame(8'h00, 8'h00, 1, 1, 1, 0, 0, 4'd1, 0, -1);
        frame(8'h00, 8'h00, 1, 1, 1, 0, 0, 4'd1, 0, -1);
        frame(8'h00, 8'h00, 1, 1, 1, 0, 0, 4'd1, 0, -1);
        frame(8'h00, 8'h00, 1, 0, 0, 0, 0, 4'd0, 1, -1);
        idle(2);
`ifdef FRAME_ALIGN_STATS_EN
        check("frame_cnt", 32'(frame_cnt), 32'd5);
        check("sync_loss_cnt", 32'(sync_loss_cnt), 32'd1);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("frame_cnt_clr", 32'(frame_cnt), 32'd0);
        check("sync_loss_cnt_clr", 32'(sync_loss_cnt), 32'd0);
`endif

        // Two good frames then a bad header while verifying.
        frame(8'hAF, 8'hAA, 0, 0, 0, 0, 0, 4'd1, 0, -1);
        frame(8'hAF, 8'hAA, 0, 0, 0, 0, 0, 4'd1, 0, -1);
        frame(8'h00, 8'h00, 0, 0, 0, 0, 0, 4'd0, 1, -1);

        // Lock on type B, then asynchronous reset mid-frame.
        frame(8'hBA, 8'h55, 0, 0, 0, 0, 1, 4'd1, 0, -1);
        frame(8'hBA, 8'h55, 0, 0, 0, 1, 1, 4'd1, 0, -1);
        frame(8'hBA, 8'h55, 0, 1, 1, 1, 1, 4'd1, 0, -1);
        send(8'hBA, 1, 4'd0, 1);
        send(8'h55, 1, 4'd1, 1);
        send(8'h32, 1, 4'd2, 1);
        send(8'h33, 1, 4'd3, 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("arst_frame_detect", 32'(bus.frame_detect), 32'd0);
        check("arst_position", 32'(bus.fr_byte_position), 32'd0);
        check("arst_hdr_type", 32'(bus.hdr_type), 32'd0);
        @(negedge clk);
        last_exp = '0;
        reset = 1'b1;
        idle(1);

        // Relock needs three fresh headers.
        frame(8'hAF, 8'hAA, 0, 0, 0, 0, 0, 4'd1, 0, -1);
        frame(8'hAF, 8'hAA, 0, 0, 0, 0, 0, 4'd1, 0, -1);
        frame(8'hAF, 8'hAA, 0, 1, 1, 0, 0, 4'd1, 0, -1);
        idle(3);
`ifdef FRAME_ALIGN_STATS_EN
        check("frame_cnt_after_rst", 32'(frame_cnt), 32'd0);
        check("sync_loss_after_rst", 32'(sync_loss_cnt), 32'd0);
`endif
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
